serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder sequencer: computes a WIDTH-bit sum using one external 1-bit full-adder cell, one bit per clock, LSB first.
- Owns operand and result shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake.
- The full-adder cell is instantiated alongside this block and is wired only through fa_i, fa_sum and fa_carry.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request to begin an addition; sampled only in IDLE.
- a, input, WIDTH, operand A; captured on the accepted start.
- b, input, WIDTH, operand B; captured on the accepted start.
- cin, input, 1, carry-in; captured on the accepted start.
- busy, output, 1, high while in RUN.
- done, output, 1, single-cycle pulse in DONE.
- sum, output, WIDTH, result; holds its value until the next accepted start completes.
- cout, output, 1, final carry-out; held like sum.
- fa_i, output, 3, to the full-adder cell: {a_bit, b_bit, carry_bit}.
- fa_sum, input, 1, sum output of the full-adder cell.
- fa_carry, input, 1, carry output of the full-adder cell.

Behaviour:
- Reset (rst high at a clock edge, in any state):
  - state goes to IDLE.
  - busy, done, cout, sum, fa_i go to 0.
  - Shift registers, carry register and counter are cleared.
  - Any operation in progress is abandoned; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - fa_i = 3'b000.
  - If start is high: load a_sh←a, b_sh←b, c_reg←cin, cnt←0, go to RUN.
  - sum and cout keep their previous values.
- RUN:
  - busy = 1.
  - fa_i = {a_sh[0], b_sh[0], c_reg}, driven combinationally from registers.
  - Each edge:
    - r_sh ← {fa_sum, r_sh[WIDTH-1:1]}.
    - c_reg ← fa_carry.
    - a_sh and b_sh shift right by one, zero-filled.
    - cnt ← cnt+1.
  - When cnt == WIDTH-1 at an edge: that edge does the final shift, then sum ← the completed result, cout ← fa_carry, and the state goes to DONE.
- DONE:
  - done = 1 for exactly this one cycle; busy = 0; fa_i = 3'b000.
  - Unconditionally go to IDLE.
  - start in this cycle is ignored.
- Latency:
  - Start accepted at edge 0.
  - RUN occupies cycles 1..WIDTH.
  - done is high during cycle WIDTH+1, and sum/cout are valid in that same cycle.
  - Throughput is one addition per WIDTH+2 cycles.
- start while busy or in DONE is ignored; it is neither queued nor able to corrupt operands.
- Changes on a, b or cin after acceptance have no effect.
- The result equals (a + b + cin) mod 2^WIDTH; cout equals bit WIDTH of the full sum.
- sum and cout are updated only at the RUN→DONE edge, never mid-operation.
- fa_sum and fa_carry are treated as purely combinational from fa_i within the same cycle.
- No X propagation: every register has a reset value, and fa_i is defined in every state.

Test Plan:
1. Reset, then start with a=8'h5A, b=8'h3C, cin=0 → fa_i LSB-first sequence begins {0,0,0},{1,0,0}; busy high for 8 cycles; done high in cycle 9; sum=8'h96, cout=0.
2. a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
3. Start accepted with a=8'h10, b=8'h01; pulse start with a=8'hAA, b=8'h55 in RUN cycle 3 and again in the DONE cycle → both ignored; result is sum=8'h11; exactly one done pulse.
4. Assert rst in RUN cycle 4 of a=8'h7F+b=8'h01 → next cycle IDLE, busy=0, sum=0, cout=0, no done pulse; a fresh start of 8'h7F+8'h01 completes with sum=8'h80.
5. Back-to-back: raise start in the first IDLE cycle after done → new op accepted; done pulses exactly WIDTH+2 cycles apart; sum holds the first result until the second done.
6. WIDTH=4 build: a=4'h9, b=4'h8, cin=1 → done in cycle 5, sum=4'h2, cout=1; random 1000-op run against a (a+b+cin) model with zero mismatches.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
//
// Adds two WIDTH-bit operands plus a carry-in. It uses one external 1-bit
// full-adder cell and processes one bit per clock, LSB first. This block
// owns the operand and result shift registers, the carry flip-flop, the bit
// counter and the start/busy/done handshake.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst      - synchronous active-high reset
//   start    - request an addition; only sampled in idle
//   a, b     - operands, captured on the accepted start
//   cin      - carry-in, captured on the accepted start
//   busy     - high while bits are being processed
//   done     - single-cycle pulse once sum/cout are valid
//   sum      - result, held until the next operation completes
//   cout     - final carry-out, held like sum
//   fa_i     - to the full-adder cell: {a_bit, b_bit, carry_bit}
//   fa_sum   - full-adder sum (combinational from fa_i)
//   fa_carry - full-adder carry (combinational from fa_i)
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [2:0]       fa_i,
  input  logic             fa_sum,
  input  logic             fa_carry
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   r_sh_q, r_sh_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          r_sh_d  = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at index 0.
        r_sh_d = {fa_sum, r_sh_q[WIDTH-1:1]};
        c_d    = fa_carry;
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LastCnt) begin
          // Publish the completed word, including this edge's final bit.
          sum_d   = r_sh_d;
          cout_d  = fa_carry;
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    fa_i = 3'b000;
    unique case (state_q)
      StRun: begin
        busy = 1'b1;
        fa_i = {a_sh_q[0], b_sh_q[0], c_q};
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl. A behavioural full-adder cell closes the loop.
// Expected results are queued by the driver and popped by a monitor on done.
module tb_serial_add_ctrl;

  localparam int W  = 8;
  localparam int W4 = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic [2:0]   fa_i;
  logic         fa_sum, fa_carry;

  logic          start4, cin4;
  logic [W4-1:0] a4, b4;
  logic          busy4, done4, cout4;
  logic [W4-1:0] sum4;
  logic [2:0]    fa_i4;
  logic          fa_sum4, fa_carry4;

  always #5 clk = ~clk;

  // Full-adder cells
  assign {fa_carry, fa_sum}   = {1'b0, fa_i[2]} + {1'b0, fa_i[1]} + {1'b0, fa_i[0]};
  assign {fa_carry4, fa_sum4} = {1'b0, fa_i4[2]} + {1'b0, fa_i4[1]} + {1'b0, fa_i4[0]};

  serial_add_ctrl #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .fa_i(fa_i), .fa_sum(fa_sum), .fa_carry(fa_carry)
  );

  serial_add_ctrl #(.WIDTH(W4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .fa_i(fa_i4), .fa_sum(fa_sum4), .fa_carry(fa_carry4)
  );

  int           n_vec = 0;
  int           n_err = 0;
  logic [W:0]   exp_q[$];
  logic [W:0]   held = '0;
  bit           mon_en = 1'b0;
  int           cyc = 0;
  int           last_done_cyc = 0;
  int           done_gap = 0;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Carry flowing into bit i of x + y + c
  function automatic logic carry_in(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic c, input int i);
    longint unsigned m, s;
    m = (64'd1 << i) - 64'd1;
    s = ({56'd0, x} & m) + ({56'd0, y} & m) + {63'd0, c};
    return s[i];
  endfunction

  // Monitor: result on done, hold of sum/cout otherwise
  always @(negedge clk) begin
    logic [W:0] e;
    cyc++;
    if (mon_en && !rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("result", {cout, sum}, e);
          held = e;
          done_gap = cyc - last_done_cyc;
          last_done_cyc = cyc;
        end
      end else begin
        check("hold", {cout, sum}, held);
      end
    end
  end

  // mode 0: quiet, 1: start pulses with AA/55 in run cycle 3 and done, 2: random pulses.
  // Called and returns just after a rising edge with the DUT idle.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                       input int mode);
    start = 1'b1; a = oa; b = ob; cin = oc;
    exp_q.push_back(ref_add(oa, ob, oc));
    @(posedge clk); #1;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int k = 0; k < W; k++) begin
      if (mode == 1 && k == 2) begin
        start = 1'b1; a = W'(8'hAA); b = W'(8'h55);
      end else if (mode == 2) begin
        start = 1'($urandom_range(0, 1)); a = W'($urandom); b = W'($urandom);
        cin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check("busy", busy, 1);
      check("done_early", done, 0);
      check("fa_i", fa_i, {oa[k], ob[k], carry_in(oa, ob, oc, k)});
      @(posedge clk); #1;
    end
    start = (mode != 0);
    if (mode == 1) begin
      a = W'(8'hAA); b = W'(8'h55);
    end else begin
      a = W'($urandom); b = W'($urandom);
    end
    @(negedge clk);
    check("done", done, 1);
    check("busy_done", busy, 0);
    check("fa_i_done", fa_i, 0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Accept an operation, then reset during run cycle k.
  task automatic start_and_abort(input logic [W-1:0] oa, input logic [W-1:0] ob,
                                 input logic oc, input int k);
    start = 1'b1; a = oa; b = ob; cin = oc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (k - 1) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    held = '0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", {cout, sum}, 0);
    check("rst_fa_i", fa_i, 0);
    @(posedge clk); #1;
  endtask

  task automatic op4(input logic [W4-1:0] oa, input logic [W4-1:0] ob, input logic oc,
                     input bit check_lat);
    logic [W4:0] e;
    int n;
    bit seen;
    e = {1'b0, oa} + {1'b0, ob} + {{W4{1'b0}}, oc};
    start4 = 1'b1; a4 = oa; b4 = ob; cin4 = oc;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = W4'($urandom); b4 = W4'($urandom);
    n = 1;
    seen = 1'b0;
    while (!seen && n <= 12) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (check_lat) check("w4_latency", n, W4 + 1);
    if (!seen) check("w4_timeout", 0, 1);
    else check("w4_result", {cout4, sum4}, e);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    held = '0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_out", {cout, sum}, 0);
    check("reset_fa_i", fa_i, 0);
    @(posedge clk); #1;

    // Basic additions and carry boundaries
    do_op(8'h5A, 8'h3C, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 0);
    do_op(8'hFF, 8'hFF, 1'b1, 0);

    // Start pulses while running and in done are ignored
    do_op(8'h10, 8'h01, 1'b0, 1);
    repeat (W + 3) begin
      @(posedge clk); #1;
    end

    // Reset mid-run abandons the operation, then a fresh run completes
    start_and_abort(8'h7F, 8'h01, 1'b0, 4);
    repeat (W + 3) begin
      @(posedge clk); #1;
    end
    do_op(8'h7F, 8'h01, 1'b0, 0);

    // Back-to-back operations
    do_op(8'h12, 8'h34, 1'b1, 0);
    do_op(8'hC8, 8'h64, 1'b0, 0);
    check("done_gap", done_gap, W + 2);

    // Randomized run with occasional aborts
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        start_and_abort(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(1, W));
      end else begin
        do_op(W'($urandom), W'($urandom), 1'($urandom), 2);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // Narrow instance
    op4(4'h9, 4'h8, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++) begin
      op4(W4'($urandom), W4'($urandom), 1'($urandom), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
